// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester handshakes and ROM macro pins around the ROM arbiter
interface rom_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 16,
  parameter int CW = 8
) ();
  logic          i_req_cu;
  logic [AW-1:0] i_addr_cu;
  logic [CW-1:0] i_wcnt_cu;
  logic          i_full_cu;
  logic          i_req_aes;
  logic [AW-1:0] i_addr_aes;
  logic [CW-1:0] i_wcnt_aes;
  logic          i_full_aes;
  logic          i_clear;
  logic [DW-1:0] i_Q;
  logic          o_CEN;
  logic [AW-1:0] o_A;
  logic [DW-1:0] o_data;
  logic          o_gnt_cu;
  logic          o_gnt_aes;
  logic          o_valid_cu;
  logic          o_valid_aes;
  logic          o_done_cu;
  logic          o_done_aes;
  modport slave (
    input  i_req_cu, i_addr_cu, i_wcnt_cu, i_full_cu,
    input  i_req_aes, i_addr_aes, i_wcnt_aes, i_full_aes,
    input  i_clear, i_Q,
    output o_CEN, o_A, o_data, o_gnt_cu, o_gnt_aes,
    output o_valid_cu, o_valid_aes, o_done_cu, o_done_aes
  );
  modport master (
    output i_req_cu, i_addr_cu, i_wcnt_cu, i_full_cu,
    output i_req_aes, i_addr_aes, i_wcnt_aes, i_full_aes,
    output i_clear, i_Q,
    input  o_CEN, o_A, o_data, o_gnt_cu, o_gnt_aes,
    input  o_valid_cu, o_valid_aes, o_done_cu, o_done_aes
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin burst arbiter sharing one 128x16 ROM macro between CU and AES
module rom_arbiter #(
  parameter int AW = 7,
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rom_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t        state_q, state_d;
  logic          cen_q, cen_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          gnt_cu_q, gnt_cu_d, gnt_aes_q, gnt_aes_d;
  logic          vld_cu_q, vld_cu_d, vld_aes_q, vld_aes_d;
  logic          done_cu_q, done_cu_d, done_aes_q, done_aes_d;
  logic          own_q, own_d;
  logic          last_q, last_d;
  logic          pend_q, pend_d;
  logic          pick_aes, full_own;
  logic [CW-1:0] wcnt_sel;
  assign pick_aes = bus.i_req_aes & (~bus.i_req_cu | ~last_q);
  assign wcnt_sel = pick_aes ? bus.i_wcnt_aes : bus.i_wcnt_cu;
  assign full_own = own_q ? bus.i_full_aes : bus.i_full_cu;
  // next state: arbitration, word issue with stall/wrap, drain and abort
  always_comb begin
    state_d    = state_q;
    cen_d      = cen_q;
    a_d        = a_q;
    rem_d      = rem_q;
    own_d      = own_q;
    last_d     = last_q;
    gnt_cu_d   = gnt_cu_q;
    gnt_aes_d  = gnt_aes_q;
    pend_d     = ~cen_q;
    data_d     = pend_q ? bus.i_Q : data_q;
    vld_cu_d   = pend_q & ~own_q;
    vld_aes_d  = pend_q & own_q;
    done_cu_d  = 1'b0;
    done_aes_d = 1'b0;
    case (state_q)
      IDLE: if (bus.i_req_cu | bus.i_req_aes) begin
        own_d     = pick_aes;
        gnt_cu_d  = ~pick_aes;
        gnt_aes_d = pick_aes;
        a_d       = pick_aes ? bus.i_addr_aes : bus.i_addr_cu;
        rem_d     = wcnt_sel - 1'b1;
        cen_d     = wcnt_sel == '0;
        state_d   = (wcnt_sel == '0) ? DRAIN : READ;
      end
      READ: if (~cen_q && rem_q == '0) begin
        state_d = DRAIN;
        cen_d   = 1'b1;
      end else begin
        a_d   = cen_q ? a_q : a_q + 1'b1;
        rem_d = cen_q ? rem_q : rem_q - 1'b1;
        cen_d = full_own;
      end
      DRAIN: begin
        done_cu_d  = ~own_q;
        done_aes_d = own_q;
        gnt_cu_d   = 1'b0;
        gnt_aes_d  = 1'b0;
        last_d     = own_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_clear) begin
      state_d    = IDLE;
      cen_d      = 1'b1;
      a_d        = a_q;
      rem_d      = rem_q;
      own_d      = own_q;
      last_d     = last_q;
      gnt_cu_d   = 1'b0;
      gnt_aes_d  = 1'b0;
      pend_d     = 1'b0;
      data_d     = data_q;
      vld_cu_d   = 1'b0;
      vld_aes_d  = 1'b0;
      done_cu_d  = 1'b0;
      done_aes_d = 1'b0;
    end
  end
  // state and output registers; AES is last owner out of reset so CU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cen_q      <= 1'b1;
      a_q        <= '0;
      data_q     <= '0;
      rem_q      <= '0;
      gnt_cu_q   <= 1'b0;
      gnt_aes_q  <= 1'b0;
      vld_cu_q   <= 1'b0;
      vld_aes_q  <= 1'b0;
      done_cu_q  <= 1'b0;
      done_aes_q <= 1'b0;
      own_q      <= 1'b0;
      last_q     <= 1'b1;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cen_q      <= cen_d;
      a_q        <= a_d;
      data_q     <= data_d;
      rem_q      <= rem_d;
      gnt_cu_q   <= gnt_cu_d;
      gnt_aes_q  <= gnt_aes_d;
      vld_cu_q   <= vld_cu_d;
      vld_aes_q  <= vld_aes_d;
      done_cu_q  <= done_cu_d;
      done_aes_q <= done_aes_d;
      own_q      <= own_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
    end
  end
  assign bus.o_CEN       = cen_q;
  assign bus.o_A         = a_q;
  assign bus.o_data      = data_q;
  assign bus.o_gnt_cu    = gnt_cu_q;
  assign bus.o_gnt_aes   = gnt_aes_q;
  assign bus.o_valid_cu  = vld_cu_q;
  assign bus.o_valid_aes = vld_aes_q;
  assign bus.o_done_cu   = done_cu_q;
  assign bus.o_done_aes  = done_aes_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and random bursts against a burst-level reference model
module tb_rom_arbiter;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errs = 0;
  int gc, g, nl;
  logic [DW-1:0] rom [128];
  rom_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();
  rom_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // ROM macro: one-cycle read latency
  always @(posedge clk) if (!bus.o_CEN) bus.i_Q <= rom[bus.o_A];
  bit busy, own, last;
  int n, issued, delivered, c;
  logic [AW-1:0] start;
  bit hist [256];
  logic [DW-1:0] m_data;
  logic e_gcu, e_gaes, e_cen, e_vcu, e_vaes, e_dcu, e_daes;
  logic [AW-1:0] e_a;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    busy = 0; last = 1; m_data = '0;
    {e_gcu, e_gaes, e_vcu, e_vaes, e_dcu, e_daes} = '0;
    e_cen = 1'b1; e_a = '0;
  endtask
  // one clock edge of the burst-level model, using the inputs the DUT sampled
  task automatic model_step();
    logic rc, ra;
    rc = bus.i_req_cu; ra = bus.i_req_aes;
    {e_vcu, e_vaes, e_dcu, e_daes} = '0;
    e_cen = 1'b1;
    if (bus.i_clear) begin
      busy = 0; e_gcu = 0; e_gaes = 0;
    end else if (busy) begin
      c++;
      hist[c % 256] = issued < n && !(own ? bus.i_full_aes : bus.i_full_cu);
      if (hist[c % 256]) begin e_a = AW'(start + issued); issued++; e_cen = 0; end
      if (c >= 2 && hist[(c - 2) % 256]) begin
        m_data = rom[AW'(start + delivered)];
        delivered++;
        e_vcu = !own; e_vaes = own;
      end
      if (delivered == n) begin
        e_dcu = !own; e_daes = own; e_gcu = 0; e_gaes = 0; busy = 0; last = own;
      end
    end else if (rc || ra) begin
      own = ra && (!rc || !last);
      n = own ? int'(bus.i_wcnt_aes) : int'(bus.i_wcnt_cu);
      start = own ? bus.i_addr_aes : bus.i_addr_cu;
      c = 0; issued = 0; delivered = 0; busy = 1;
      e_gcu = !own; e_gaes = own;
      hist[0] = n != 0;
      if (n != 0) begin e_a = start; issued = 1; e_cen = 0; end
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    model_step();
    chk("ctl{gcu,gaes,cen,vcu,vaes,dcu,daes}",
        32'({bus.o_gnt_cu, bus.o_gnt_aes, bus.o_CEN, bus.o_valid_cu, bus.o_valid_aes, bus.o_done_cu, bus.o_done_aes}),
        32'({e_gcu, e_gaes, e_cen, e_vcu, e_vaes, e_dcu, e_daes}));
    if (!e_cen) chk("addr", 32'(bus.o_A), 32'(e_a));
    chk("data", 32'(bus.o_data), 32'(m_data));
  endtask
  task automatic rst_chk();
    chk("rst_ctl", 32'({bus.o_gnt_cu, bus.o_gnt_aes, bus.o_CEN, bus.o_valid_cu, bus.o_valid_aes, bus.o_done_cu, bus.o_done_aes}), 32'h10);
    chk("rst_addr", 32'(bus.o_A), 32'h0);
    chk("rst_data", 32'(bus.o_data), 32'h0);
  endtask
  task automatic req(input bit aes, input int a, input int w);
    if (aes) begin bus.i_addr_aes = AW'(a); bus.i_wcnt_aes = CW'(w); bus.i_req_aes = 1'b1; end
    else begin bus.i_addr_cu = AW'(a); bus.i_wcnt_cu = CW'(w); bus.i_req_cu = 1'b1; end
  endtask
  task automatic wait_done(input bit aes, output int gcnt);
    bit seen;
    gcnt = 0; seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      cyc();
      gcnt += aes ? int'(bus.o_gnt_aes) : int'(bus.o_gnt_cu);
      seen = aes ? bus.o_done_aes : bus.o_done_cu;
    end
    if (aes) bus.i_req_aes = 1'b0; else bus.i_req_cu = 1'b0;
    chk(aes ? "done_seen_aes" : "done_seen_cu", 32'(seen), 32'h1);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) rom[i] = DW'($urandom);
    {bus.i_req_cu, bus.i_full_cu, bus.i_req_aes, bus.i_full_aes, bus.i_clear} = '0;
    bus.i_addr_cu = '0; bus.i_wcnt_cu = '0; bus.i_addr_aes = '0; bus.i_wcnt_aes = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #12 rst_chk();
    @(negedge clk) rst_n = 1'b1;
    req(0, 'h10, 3); wait_done(0, gc); chk("cu3_gnt_cycles", gc, 4);
    req(0, 'h20, 8); req(1, 'h40, 8);
    wait_done(0, gc); chk("cu8_gnt_cycles", gc, 9);
    wait_done(1, gc); chk("aes8_gnt_cycles", gc, 9);
    req(0, 'h33, 8); req(1, 'h44, 8);
    cyc(); chk("rr_cu_wins_again", 32'(bus.o_gnt_cu), 32'h1);
    wait_done(0, gc); chk("cu8b_gnt_cycles", gc, 8);
    wait_done(1, gc); chk("aes8b_gnt_cycles", gc, 9);
    req(1, 'h7E, 4); wait_done(1, gc); chk("aes_wrap_gnt_cycles", gc, 5);
    req(0, 'h30, 6); g = 0; nl = 0;
    for (int k = 0; k < 20 && nl < 2; k++) begin cyc(); g += int'(bus.o_gnt_cu); nl += int'(!bus.o_CEN); end
    bus.i_full_cu = 1'b1;
    repeat (3) begin cyc(); g += int'(bus.o_gnt_cu); end
    bus.i_full_cu = 1'b0;
    wait_done(0, gc); chk("stall_gnt_cycles", g + gc, 10);
    req(0, 'h55, 0); wait_done(0, gc); chk("zero_gnt_cycles", gc, 1);
    req(0, 'h70, 8); req(1, 'h08, 3);
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    #1 rst_chk(); model_reset();
    @(negedge clk) rst_n = 1'b1;
    cyc(); chk("rst_tie_cu", 32'(bus.o_gnt_cu), 32'h1);
    wait_done(0, gc); chk("post_rst_cu_gnt", gc, 8);
    wait_done(1, gc); chk("post_rst_aes_gnt", gc, 4);
    req(0, 'h60, 8); nl = 0;
    for (int k = 0; k < 20 && nl < 3; k++) begin cyc(); nl += int'(!bus.o_CEN); end
    req(1, 'h05, 2); bus.i_clear = 1'b1;
    cyc(); bus.i_clear = 1'b0;
    chk("clear_state", 32'({bus.o_gnt_cu, bus.o_gnt_aes, bus.o_CEN, bus.o_done_cu}), 32'h2);
    bus.i_req_cu = 1'b0;
    wait_done(1, gc); chk("after_clear_aes_gnt", gc, 3);
    for (int k = 0; k < 4000; k++) begin
      cyc();
      if (bus.o_done_cu) bus.i_req_cu = 1'b0;
      else if (!bus.i_req_cu && $urandom_range(0, 3) == 0) req(0, $urandom_range(0, 127), $urandom_range(0, 12));
      if (bus.o_done_aes) bus.i_req_aes = 1'b0;
      else if (!bus.i_req_aes && $urandom_range(0, 3) == 0) req(1, $urandom_range(0, 127), $urandom_range(0, 12));
      if (bus.o_gnt_cu && $urandom_range(0, 15) == 0) bus.i_req_cu = 1'b0;
      if (bus.o_gnt_aes && $urandom_range(0, 15) == 0) bus.i_req_aes = 1'b0;
      bus.i_full_cu = $urandom_range(0, 3) == 0;
      bus.i_full_aes = $urandom_range(0, 3) == 0;
      bus.i_clear = $urandom_range(0, 59) == 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single 128x16 tag ROM macro between two requesters: the control unit (EPC/TID/user reads, RNG seed fetch) and the AES controller (128-bit key fetch).
- Grants whole bursts and streams one word per cycle with a 1-cycle macro read latency.
- Supports per-requester backpressure and a synchronous abort.
- Drives the macro pins CEN/A directly and sits between the control/AES logic and the ROM pads in tag_digital_core.

Parameters:
- AW, 7, ROM address width.
- DW, 16, ROM data width.
- CW, 8, burst word-count width.

Ports:
- clk  input  1  gated ROM-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- i_req_cu  input  1  control-unit burst request (level, held until o_done_cu).
- i_addr_cu  input  AW  control-unit start word address.
- i_wcnt_cu  input  CW  control-unit word count.
- i_full_cu  input  1  control-unit FIFO full; stalls its burst.
- i_req_aes  input  1  AES-controller burst request.
- i_addr_aes  input  AW  AES start word address.
- i_wcnt_aes  input  CW  AES word count.
- i_full_aes  input  1  AES sink full; stalls its burst.
- i_clear  input  1  synchronous abort (from clear_cu).
- i_Q  input  DW  ROM macro read data.
- o_CEN  output  1  ROM chip enable, active low.
- o_A  output  AW  ROM address.
- o_data  output  DW  registered read word, shared by both requesters.
- o_gnt_cu  output  1  burst owned by the control unit.
- o_gnt_aes  output  1  burst owned by AES.
- o_valid_cu  output  1  o_data valid for the control unit (1-cycle pulse per word).
- o_valid_aes  output  1  o_data valid for AES.
- o_done_cu  output  1  control-unit burst complete (1-cycle pulse).
- o_done_aes  output  1  AES burst complete.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - o_CEN=1, o_A=0, o_data=0.
  - All gnt/valid/done outputs 0.
  - State IDLE; last-owner register = AES, so the control unit wins the first tie.
- All outputs are registered.
- States: IDLE, READ, DRAIN.
- IDLE:
  - No request: stay in IDLE, o_CEN=1.
  - Exactly one request: grant it.
  - Both requesting: grant the one that was not last owner (round-robin).
  - On grant, latch addr and wcnt; owner gnt goes high on the next edge.
  - wcnt=0: no ROM access. done pulses 1 cycle after grant, gnt drops with it, and the FSM returns to IDLE.
  - wcnt≠0: enter READ with o_CEN=0 and o_A=start address in the same cycle gnt rises.
- READ, each cycle with o_CEN=0:
  - On the next edge o_data<=i_Q and the owner's valid pulses.
  - Address increments modulo 2^AW (127 wraps to 0); remaining count decrements.
  - Owner full=1 at the edge: o_CEN<=1 and the address is held; the word already in flight still delivers its valid. Issue resumes the cycle after full deasserts.
  - When the last word is issued, enter DRAIN with o_CEN<=1.
- DRAIN:
  - Last valid and done pulse in the same cycle.
  - gnt deasserts on that edge; last-owner updates; FSM returns to IDLE.
  - Minimum 1 idle cycle between bursts; re-arbitration happens in the cycle after done.
- Throughput: 1 word/cycle unstalled. A burst of N words has done N+1 cycles after gnt rises.
- Deassertion of the owner's req mid-burst is ignored; the burst completes.
- Requests arriving during a burst wait; they are never dropped while held.
- i_clear (any state, priority over everything except reset):
  - Next edge: IDLE, o_CEN=1, gnt/valid/done=0, no done pulse.
  - o_data and last-owner are retained.
- gnt_cu and gnt_aes are never high together. valid/done only pulse for the current owner.
- An asynchronous reset mid-burst returns all outputs to reset values immediately.

Test Plan:
- CU only, addr=0x10, wcnt=3, ROM model returns addr-based data -> o_A sequence 0x10,0x11,0x12; o_data 0x0010,0x0011,0x0012 with o_valid_cu pulses on consecutive cycles; o_done_cu with the third valid; gnt_cu high 4 cycles.
- Simultaneous requests, both wcnt=8 -> CU served first; AES granted 1 cycle after o_done_cu. Repeat both requests -> CU wins again because AES was last owner. Verify gnt exclusivity throughout.
- AES addr=0x7E, wcnt=4 -> o_A 0x7E,0x7F,0x00,0x01.
- CU wcnt=6 with i_full_cu high for 3 cycles after word 2 issues -> word 2 still valid, no CEN low during stall, words 3-6 follow without loss or duplication; done 3 cycles later than the unstalled case.
- wcnt=0 request -> no o_CEN low, o_done pulse 1 cycle after gnt. i_clear asserted mid-burst after word 3 of 8 -> next cycle IDLE, o_CEN=1, no done pulse, pending AES request granted afterward.
- Assert rst_n low mid-burst asynchronously -> outputs at reset values before the next clock edge; after release the CU wins the first tie.
